// File: rtl/vending_controller.sv
// vending_controller: coin-operated vending FSM with credit, item vend and greedy change.
// Define VEND_STOCK_EN to add per-item stock counters, sold-out errors and restock.
module vending_controller #(
    parameter int N_ITEMS    = 4,
    parameter int CW         = 16,
    parameter int PRICE_W    = 8,
    parameter int CREDIT_MAX = 995,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       coin_5,
    input  logic                       coin_10,
    input  logic                       coin_50,
    input  logic [N_ITEMS-1:0]         item_sel,
    input  logic [N_ITEMS*PRICE_W-1:0] item_price,
    input  logic                       cash_back,
    input  logic                       restock,
    output logic [CW-1:0]              credit,
    output logic                       vend_valid,
    output logic [3:0]                 vend_item,
    input  logic                       vend_ready,
    output logic                       change_valid,
    output logic [1:0]                 change_coin,
    input  logic                       change_ready,
    output logic                       busy,
    output logic                       err_insufficient,
    output logic                       err_overflow,
    output logic                       err_soldout,
    output logic                       coin_reject
);
    localparam int LW = N_ITEMS + 4;
    localparam int IW = $clog2(N_ITEMS);
    localparam logic [CW-1:0] V5   = CW'(5);
    localparam logic [CW-1:0] V10  = CW'(10);
    localparam logic [CW-1:0] V50  = CW'(50);
    localparam logic [CW:0]   MAXC = (CW+1)'(CREDIT_MAX);

    typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

    state_t        state_q;
    logic [LW-1:0] lvl_q, hist_q, ev;
    logic [CW-1:0] credit_q;
    logic [3:0]    vend_item_q;
    logic [1:0]    change_coin_q;
    logic          ins_q, ovf_q, sold_q, rej_q;

    logic [CW-1:0]      coin_sum, after_coins, coin_val, change_left;
    logic [CW:0]        coin_total;
    logic               coin_ev, coin_ovf, item_ev, soldout;
    logic [3:0]         sel_idx;
    logic [PRICE_W-1:0] sel_price;

    function automatic logic [1:0] greedy(input logic [CW-1:0] c);
        return c >= V50 ? 2'd3 : c >= V10 ? 2'd2 : 2'd1;
    endfunction

    // ev bits: [0] coin_5, [1] coin_10, [2] coin_50, [3] cash_back, [4+i] item i
    assign ev = lvl_q & ~hist_q;

    always_comb begin
        coin_sum    = (ev[0] ? V5 : '0) + (ev[1] ? V10 : '0) + (ev[2] ? V50 : '0);
        coin_total  = {1'b0, credit_q} + {1'b0, coin_sum};
        coin_ev     = |ev[2:0];
        coin_ovf    = coin_total > MAXC;
        after_coins = coin_ovf ? credit_q : coin_total[CW-1:0];
        item_ev     = |ev[4 +: N_ITEMS];
        sel_idx     = '0;
        sel_price   = '0;
        for (int i = N_ITEMS - 1; i >= 0; i--) begin
            if (ev[4+i]) begin
                sel_idx   = 4'(i);
                sel_price = item_price[i*PRICE_W +: PRICE_W];
            end
        end
        coin_val    = change_coin_q == 2'd3 ? V50 : change_coin_q == 2'd2 ? V10 : V5;
        change_left = credit_q - coin_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            lvl_q         <= '1;
            hist_q        <= '1;
            credit_q      <= '0;
            vend_item_q   <= '0;
            change_coin_q <= '0;
            ins_q         <= 1'b0;
            ovf_q         <= 1'b0;
            sold_q        <= 1'b0;
            rej_q         <= 1'b0;
        end else begin
            lvl_q  <= {item_sel, cash_back, coin_50, coin_10, coin_5};
            hist_q <= lvl_q;
            ins_q  <= 1'b0;
            ovf_q  <= 1'b0;
            sold_q <= 1'b0;
            rej_q  <= coin_ev && (state_q != IDLE || coin_ovf);
            case (state_q)
                IDLE: begin
                    ovf_q    <= coin_ev && coin_ovf;
                    credit_q <= after_coins;
                    if (ev[3]) begin
                        if (after_coins >= V5) begin
                            state_q       <= CHANGE;
                            change_coin_q <= greedy(after_coins);
                        end else begin
                            credit_q <= '0;
                        end
                    end else if (item_ev) begin
                        if (soldout) begin
                            sold_q <= 1'b1;
                        end else if (after_coins >= CW'(sel_price)) begin
                            credit_q    <= after_coins - CW'(sel_price);
                            vend_item_q <= sel_idx;
                            state_q     <= VEND;
                        end else begin
                            ins_q <= 1'b1;
                        end
                    end
                end
                VEND: if (vend_ready) state_q <= IDLE;
                CHANGE: begin
                    // residue below the smallest coin is forfeited
                    if (change_ready) begin
                        if (change_left < V5) begin
                            credit_q <= '0;
                            state_q  <= IDLE;
                        end else begin
                            credit_q      <= change_left;
                            change_coin_q <= greedy(change_left);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef VEND_STOCK_EN
    logic [STOCK_W-1:0] stock_q [N_ITEMS];
    logic               rs_lvl_q, rs_hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_lvl_q  <= 1'b1;
            rs_hist_q <= 1'b1;
            for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
        end else begin
            rs_lvl_q  <= restock;
            rs_hist_q <= rs_lvl_q;
            if (state_q == IDLE && rs_lvl_q && !rs_hist_q) begin
                for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
            end else if (state_q == VEND && vend_ready) begin
                stock_q[vend_item_q[IW-1:0]] <= stock_q[vend_item_q[IW-1:0]] - STOCK_W'(1);
            end
        end
    end

    assign soldout = stock_q[sel_idx[IW-1:0]] == '0;
`else
    logic unused_restock;
    assign unused_restock = restock;
    assign soldout        = 1'b0;
`endif

    assign credit           = credit_q;
    assign vend_valid       = state_q == VEND;
    assign vend_item        = vend_item_q;
    assign change_valid     = state_q == CHANGE;
    assign change_coin      = change_coin_q;
    assign busy             = state_q != IDLE;
    assign err_insufficient = ins_q;
    assign err_overflow     = ovf_q;
    assign err_soldout      = sold_q;
    assign coin_reject      = rej_q;
endmodule

// File: tb/tb_vending_controller.sv
// tb_vending_controller: directed and randomized checks of vending_controller against a
// transaction-level credit/stock/change model.
module tb_vending_controller;
    localparam int N     = 4;
    localparam int CW    = 16;
    localparam int PW    = 8;
    localparam int MAXC  = 995;
    localparam int SINIT = 1;
`ifdef VEND_STOCK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          coin_5 = 0, coin_10 = 0, coin_50 = 0, cash_back = 0, restock = 0;
    logic [N-1:0]  item_sel = '0;
    logic [N*PW-1:0] item_price = '0;
    logic          vend_ready = 1'b1, change_ready = 1'b1;
    logic [CW-1:0] credit;
    logic          vend_valid, change_valid, busy;
    logic [3:0]    vend_item;
    logic [1:0]    change_coin;
    logic          err_insufficient, err_overflow, err_soldout, coin_reject;

    vending_controller #(.N_ITEMS(N), .CW(CW), .PRICE_W(PW), .CREDIT_MAX(MAXC),
                         .STOCK_W(4), .STOCK_INIT(SINIT)) dut (
        .clk(clk), .rst_n(rst_n), .coin_5(coin_5), .coin_10(coin_10), .coin_50(coin_50),
        .item_sel(item_sel), .item_price(item_price), .cash_back(cash_back), .restock(restock),
        .credit(credit), .vend_valid(vend_valid), .vend_item(vend_item), .vend_ready(vend_ready),
        .change_valid(change_valid), .change_coin(change_coin), .change_ready(change_ready),
        .busy(busy), .err_insufficient(err_insufficient), .err_overflow(err_overflow),
        .err_soldout(err_soldout), .coin_reject(coin_reject));

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    int price [N];
    int m_credit = 0;
    int m_stock [N];
    int c_ovf = 0, c_rej = 0, c_ins = 0, c_sold = 0;
    int vlog[$], clog[$];
    int o0, r0, i0, s0, v0, k0;
    int e_ovf, e_rej, e_ins, e_sold, e_vend;
    int ecq[$];
    bit rnd_rdy = 1'b0;
    logic vr_set = 1'b1, cr_set = 1'b1;

    always @(negedge clk) begin
        if (rst_n) begin
            c_ovf  += int'(err_overflow);
            c_rej  += int'(coin_reject);
            c_ins  += int'(err_insufficient);
            c_sold += int'(err_soldout);
            if (vend_valid && vend_ready) vlog.push_back(int'(vend_item));
            if (change_valid && change_ready) clog.push_back(int'(change_coin));
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        vend_ready   = rnd_rdy ? 1'($urandom_range(0, 1)) : vr_set;
        change_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : cr_set;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_prices();
        for (int i = 0; i < N; i++) item_price[i*PW +: PW] = PW'(price[i]);
    endtask

    task automatic drive(input logic [2:0] coins, input logic [N-1:0] items, input logic cb, input logic rs);
        @(posedge clk);
        #1;
        {coin_50, coin_10, coin_5} = coins;
        item_sel = items; cash_back = cb; restock = rs;
        @(posedge clk);
        #1;
        {coin_50, coin_10, coin_5} = 3'b000;
        item_sel = '0; cash_back = 1'b0; restock = 1'b0;
    endtask

    // model one IDLE transaction from the rules, then drive it
    task automatic start(input logic [2:0] coins, input logic [N-1:0] items, input logic cb, input logic rs);
        int sum, cr, idx;
        o0 = c_ovf; r0 = c_rej; i0 = c_ins; s0 = c_sold; v0 = vlog.size(); k0 = clog.size();
        e_ins = 0; e_sold = 0; e_vend = -1;
        ecq.delete();
        sum = (coins[0] ? 5 : 0) + (coins[1] ? 10 : 0) + (coins[2] ? 50 : 0);
        e_ovf = (sum > 0 && m_credit + sum > MAXC) ? 1 : 0;
        e_rej = e_ovf;
        cr = e_ovf ? m_credit : m_credit + sum;
        if (cb) begin
            if (cr >= 5) begin
                repeat (cr / 50) ecq.push_back(3);
                repeat ((cr % 50) / 10) ecq.push_back(2);
                repeat ((cr % 10) / 5) ecq.push_back(1);
            end
            cr = 0;
        end else if (items != 0) begin
            idx = 0;
            while (!items[idx]) idx++;
            if (STK && m_stock[idx] == 0) e_sold = 1;
            else if (cr >= price[idx]) begin
                cr -= price[idx];
                e_vend = idx;
            end else e_ins = 1;
        end
        if (rs && STK) for (int i = 0; i < N; i++) m_stock[i] = SINIT;
        if (e_vend >= 0 && STK) m_stock[e_vend]--;
        m_credit = cr;
        drive(coins, items, cb, rs);
    endtask

    task automatic finish(input string tag);
        int n;
        repeat (2) @(negedge clk);
        n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        #2;
        chk({tag, ".idle"}, int'(busy), 0);
        chk({tag, ".credit"}, int'(credit), m_credit);
        chk({tag, ".overflow"}, c_ovf - o0, e_ovf);
        chk({tag, ".reject"}, c_rej - r0, e_rej);
        chk({tag, ".insufficient"}, c_ins - i0, e_ins);
        chk({tag, ".soldout"}, c_sold - s0, e_sold);
        chk({tag, ".vends"}, vlog.size() - v0, e_vend >= 0 ? 1 : 0);
        if (e_vend >= 0 && vlog.size() > v0) chk({tag, ".item"}, vlog[v0], e_vend);
        chk({tag, ".ncoins"}, clog.size() - k0, ecq.size());
        for (int j = 0; j < ecq.size(); j++)
            chk($sformatf("%s.coin%0d", tag, j), (k0 + j < clog.size()) ? clog[k0 + j] : -1, ecq[j]);
    endtask

    task automatic zero_outputs(input string tag);
        chk({tag, ".credit"}, int'(credit), 0);
        chk({tag, ".outs"}, int'({vend_valid, vend_item, change_valid, change_coin, busy,
                                  err_insufficient, err_overflow, err_soldout, coin_reject}), 0);
    endtask

    initial begin
        price = '{15, 5, 20, 25};
        set_prices();
        for (int i = 0; i < N; i++) m_stock[i] = SINIT;
        #3;
        zero_outputs("reset");
        coin_5 = 1'b1;
        #14 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("held_high.credit", int'(credit), 0);
        chk("held_high.busy", int'(busy), 0);
        coin_5 = 1'b0;

        start(3'b100, '0, 0, 0); finish("coin50");
        vr_set = 1'b0;
        start(3'b000, 4'b0001, 0, 0);
        repeat (2) @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("hold%0d.valid", c), int'(vend_valid), 1);
            chk($sformatf("hold%0d.item", c), int'(vend_item), 0);
            chk($sformatf("hold%0d.credit", c), int'(credit), 35);
        end
        drive(3'b010, 4'b0010, 1, 0);
        e_rej += 1;
        repeat (2) @(negedge clk);
        chk("vend_busy.busy", int'(busy), 1);
        chk("vend_busy.credit", int'(credit), 35);
        vr_set = 1'b1;
        finish("item0");

        start(3'b000, '0, 1, 0); finish("refund35");
        start(3'b010, '0, 0, 0); finish("coin10");
        start(3'b000, 4'b1000, 0, 0); finish("insufficient");
        start(3'b111, '0, 0, 0); finish("three_coins");
        start(3'b010, '0, 0, 0); finish("to85");
        start(3'b000, '0, 1, 0); finish("refund85");

        repeat (19) begin start(3'b100, '0, 0, 0); finish("fill50"); end
        repeat (4) begin start(3'b010, '0, 0, 0); finish("fill10"); end
        start(3'b010, '0, 0, 0); finish("overflow990");
        start(3'b001, '0, 0, 0); finish("exact_max");
        start(3'b001, '0, 0, 0); finish("overflow995");
        start(3'b000, '0, 1, 0); finish("refund995");

        start(3'b001, 4'b0010, 0, 0); finish("coin_and_item1");

        start(3'b100, '0, 0, 0); finish("stock.fund");
        start(3'b000, 4'b0100, 0, 0); finish("stock.buy1");
        start(3'b000, 4'b0100, 0, 0); finish("stock.buy2");
        start(3'b000, '0, 0, 1); finish("stock.restock");
        start(3'b100, '0, 0, 0); finish("stock.fund2");
        start(3'b000, 4'b0100, 0, 0); finish("stock.buy3");
        start(3'b000, '0, 1, 0); finish("stock.drain");

        start(3'b100, '0, 0, 0); finish("abort.fund");
        vr_set = 1'b0;
        start(3'b000, 4'b0001, 0, 0);
        repeat (3) @(negedge clk);
        chk("abort.busy", int'(busy), 1);
        coin_10 = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        zero_outputs("abort");
        m_credit = 0;
        for (int i = 0; i < N; i++) m_stock[i] = SINIT;
        vr_set = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort.after_release", int'(credit), 0);
        coin_10 = 1'b0;
        start(3'b001, '0, 0, 0); finish("abort.recover");

        rnd_rdy = 1'b1;
        for (int i = 0; i < N; i++) price[i] = $urandom_range(1, 80);
        set_prices();
        for (int t = 0; t < 80; t++) begin
            start(3'($urandom_range(0, 7)),
                  $urandom_range(0, 2) == 0 ? N'(0) : N'($urandom_range(0, (1 << N) - 1)),
                  $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
            finish($sformatf("rand%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
